// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIX,
      DONE
   } div_state_t;

   localparam int DIV_WIDTH   = 32;
   localparam int DIV_LATENCY = DIV_WIDTH + 2;

   // Widest operand the negate helper supports; callers zero-extend into it
   // and truncate the result back to their own width.
   localparam int NEG_W = 64;

   // Two's-complement negate when neg is set, pass-through otherwise.
   function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] val,
                                                  input logic             neg);
      return neg ? ({NEG_W{1'b0}} - val) : val;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {rem, quo} left by one and trial-subtract
// the divisor magnitude; keep the difference and set the quotient bit when the
// subtraction does not borrow.
module div_restore_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   // The shifted remainder can reach 2*dvs-1, so the trial subtract is one bit
   // wider than the operands; its top bit is the borrow.
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Trial subtract and restore selection.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      if (!diff[WIDTH]) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/axis_iter_divider.sv
// Iterative restoring divider with AXI-Stream style operand and result channels.
// One operation takes WIDTH+3 cycles: PREP, WIDTH restoring steps, FIX, DONE.
module axis_iter_divider
   import div_pkg::*;
#(
   parameter bit SIGNED = 1'b1,
   parameter int WIDTH  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               abort,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   output logic               m_axis_dout_tvalid,
   input  logic               m_axis_dout_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_t       state;
   div_state_t       state_next;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] opa;        // latched dividend
   logic [WIDTH-1:0] opb;        // latched divisor
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;        // divisor magnitude
   logic             q_neg;
   logic             r_neg;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             both_valid;
   logic             last_step;

   assign both_valid = s_axis_divisor_tvalid && s_axis_dividend_tvalid;
   assign last_step  = (count == CNT_W'(WIDTH - 1));

   // Both operand channels are accepted together, only while idle.
   assign s_axis_divisor_tready  = (state == IDLE);
   assign s_axis_dividend_tready = (state == IDLE);
   assign m_axis_dout_tvalid     = (state == DONE);

   // Operand magnitudes (signed mode) and final sign correction.
   assign mag_a = WIDTH'(cond_neg(NEG_W'(opa), SIGNED && opa[WIDTH-1]));
   assign mag_b = WIDTH'(cond_neg(NEG_W'(opb), SIGNED && opb[WIDTH-1]));
   assign q_fix = WIDTH'(cond_neg(NEG_W'(quo), q_neg));
   assign r_fix = WIDTH'(cond_neg(NEG_W'(rem), r_neg));

   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem      (rem),
      .quo      (quo),
      .dvs      (dvs),
      .rem_next (rem_step),
      .quo_next (quo_step)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; abort wins over accept and over the result handshake.
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (both_valid) state_next = PREP;
            PREP:    state_next = ITER;
            ITER:    if (last_step) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (m_axis_dout_tready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Datapath: latch operands, set up magnitudes and signs, iterate, publish.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count             <= '0;
         opa               <= '0;
         opb               <= '0;
         rem               <= '0;
         quo               <= '0;
         dvs               <= '0;
         q_neg             <= 1'b0;
         r_neg             <= 1'b0;
         m_axis_dout_tdata <= '0;
      end else if (!abort) begin
         case (state)
            IDLE: begin
               if (both_valid) begin
                  opa <= s_axis_dividend_tdata;
                  opb <= s_axis_divisor_tdata;
               end
            end
            PREP: begin
               quo   <= mag_a;
               dvs   <= mag_b;
               rem   <= '0;
               count <= '0;
               q_neg <= SIGNED && (opa[WIDTH-1] ^ opb[WIDTH-1]);
               r_neg <= SIGNED && opa[WIDTH-1];
            end
            ITER: begin
               rem   <= rem_step;
               quo   <= quo_step;
               count <= count + 1'b1;
            end
            FIX: begin
               m_axis_dout_tdata <= {q_fix, r_fix};
            end
            default: ;
         endcase
      end
   end

endmodule
